// File: rtl/raster_coord_gen_pkg.sv
// raster_coord_gen_pkg: shared defaults, coordinate type and scan state for the raster source
package raster_coord_gen_pkg;
  localparam int RASTER_H_RES = 640;
  localparam int RASTER_V_RES = 480;
  typedef logic [31:0] fp_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} raster_state_e;
  function automatic fp_t coord_to_fp(input logic [15:0] c, input int frac);
    return fp_t'(c) << frac;
  endfunction
endpackage

// File: rtl/raster_coord_gen_credit_counter.sv
// raster_coord_gen_credit_counter: saturating up/down count of beats issued but not yet retired
module raster_coord_gen_credit_counter #(
  parameter int CREDITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(CREDITS+1)-1:0] used,
  output logic                         avail
);
  localparam int CW = $clog2(CREDITS + 1);
  logic up, dn;
  logic [CW-1:0] nxt;
  assign up = inc && used != CW'(CREDITS);
  assign dn = dec && used != '0;
  assign nxt = (up && !dn) ? used + CW'(1) : (dn && !up) ? used - CW'(1) : used;
  // avail looks at next cycle's count so the issuing side can register its valid
  assign avail = nxt < CW'(CREDITS);
  always_ff @(posedge clk or negedge rst)
    if (!rst) used <= '0;
    else used <= nxt;
endmodule

// File: rtl/raster_coord_gen.sv
// raster_coord_gen: scans an H_RES x V_RES frame, emitting fixed-point pixel coordinates over valid/ready
module raster_coord_gen
  import raster_coord_gen_pkg::*;
#(
  parameter int H_RES     = RASTER_H_RES,
  parameter int V_RES     = RASTER_V_RES,
  parameter int LANES     = 1,
  parameter int FRAC_BITS = 21,
  parameter int FP_W      = 32,
  parameter int CREDITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  stop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*FP_W-1:0] screen_x,
  output logic [FP_W-1:0]       screen_y,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  input  logic                  ret_valid,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);
  localparam int XW = H_RES > 1 ? $clog2(H_RES) : 1;
  localparam int YW = V_RES > 1 ? $clog2(V_RES) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  raster_state_e state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] used;
  logic stop_pend, acc, last_x, last_y, frame_end, roll, avail, valid_nxt;
  assign acc = out_valid && out_ready;
  assign last_x = x == XW'(H_RES - LANES);
  assign last_y = y == YW'(V_RES - 1);
  assign frame_end = acc && last_x && last_y;
  assign roll = continuous && !stop_pend && !stop;
  raster_coord_gen_credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk(clk), .rst(rst), .inc(acc), .dec(ret_valid), .used(used), .avail(avail)
  );
  always_comb begin
    state_nxt = (state == IDLE && start) ? RUN :
                (state == RUN && frame_end && !roll) ? DRAIN :
                (state == DRAIN && used == '0) ? IDLE : state;
    valid_nxt = state_nxt == RUN && avail;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      stop_pend <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      stop_pend <= state_nxt == RUN && (stop_pend || (state == RUN && stop));
      if (acc) begin
        x <= last_x ? '0 : x + XW'(LANES);
        if (last_x) y <= last_y ? '0 : y + YW'(1);
      end
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  // beat fields are pure decodes of registered scan state, gated so idle outputs read as zero
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign screen_x[i*FP_W +: FP_W] = out_valid ? (FP_W'(x) + FP_W'(i)) << FRAC_BITS : '0;
  end
  assign screen_y = out_valid ? FP_W'(y) << FRAC_BITS : '0;
  assign sof = out_valid && x == '0 && y == '0;
  assign eol = out_valid && last_x;
  assign eof = eol && last_y;
  assign busy = state != IDLE || used != '0;
endmodule

// File: tb/tb_raster_coord_gen.sv
// tb_raster_coord_gen: table, hand-written and randomized checks against a pixel-index reference model
module tb_raster_coord_gen;
  localparam int H = 8, V = 2, L = 4, C = 2, BPL = H / L, BPF = BPL * V;
  logic clk = 0, rst = 0, start = 0, continuous = 0, stop = 0, out_ready = 0, ret_valid = 0;
  logic out_valid, sof, eol, eof, busy;
  logic [L*32-1:0] screen_x;
  logic [31:0] screen_y;
  logic [15:0] frame_cnt;

  raster_coord_gen #(.H_RES(H), .V_RES(V), .LANES(L), .FRAC_BITS(21), .FP_W(32), .CREDITS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .out_valid(out_valid), .out_ready(out_ready), .screen_x(screen_x), .screen_y(screen_y),
    .sof(sof), .eol(eol), .eof(eof), .ret_valid(ret_valid), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc_no = 0, pix = 0, exp_frames = 0, outstanding = 0, n_acc = 0, n_sof = 0;
  int ret_q[$];
  bit echo = 0, run_model = 0, stop_seen = 0, stall = 0;
  logic [L*32-1:0] sx_s;
  logic [31:0] sy_s;
  logic [2:0] fl_s;

  typedef struct {
    bit rdy, ret, v;
    int x, y;
    bit sof, eol, eof, busy;
    int fc;
  } row_t;
  row_t tv[10];

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [L*32-1:0] lanes(int xv);
    logic [L*32-1:0] r = '0;
    for (int i = 0; i < L; i++) r[i*32 +: 32] = 32'(xv + i) << 21;
    return r;
  endfunction

  task automatic model_clear();
    pix = 0; exp_frames = 0; outstanding = 0; ret_q.delete();
    run_model = 0; stop_seen = 0; stall = 0;
  endtask

  // drive one cycle from posedge+1, check what the DUT presents, advance the model, step a clock
  task automatic cyc(input bit rdy, input bit rt);
    bit rv;
    rv = rt;
    if (echo && ret_q.size() > 0 && ret_q[0] <= cyc_no) begin
      rv = 1;
      void'(ret_q.pop_front());
    end
    out_ready = rdy;
    ret_valid = rv;
    chk("frame_cnt", frame_cnt, 128'(exp_frames));
    if (stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_x", screen_x, sx_s);
      chk("stall_y", screen_y, sy_s);
      chk("stall_flags", {sof, eol, eof}, fl_s);
    end
    if (out_valid) chk("credit_cap", out_valid && outstanding >= C, 0);
    if (rv && outstanding > 0) outstanding--;
    if (out_valid && rdy) begin
      chk("beat_expected", run_model, 1);
      chk("beat_x", screen_x, lanes((pix % BPL) * L));
      chk("beat_y", screen_y, 128'(32'(pix / BPL) << 21));
      chk("beat_sof", sof, pix == 0);
      chk("beat_eol", eol, pix % BPL == BPL - 1);
      chk("beat_eof", eof, pix == BPF - 1);
      n_sof += int'(sof);
      n_acc++;
      outstanding++;
      if (echo) ret_q.push_back(cyc_no + 3);
      pix++;
      if (pix == BPF) begin
        pix = 0;
        exp_frames++;
        if (!continuous || stop_seen) begin
          run_model = 0;
          stop_seen = 0;
        end
      end
    end
    stall = out_valid && !rdy;
    sx_s = screen_x; sy_s = screen_y; fl_s = {sof, eol, eof};
    @(posedge clk); #1;
    cyc_no++;
  endtask

  task automatic do_start();
    start = 1;
    run_model = 1;
    cyc(0, 0);
    start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1;
    if (run_model) stop_seen = 1;
    cyc(1, 0);
    stop = 0;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      cyc(1, 0);
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_x"}, screen_x, 0);
    chk({tag, "_y"}, screen_y, 0);
    chk({tag, "_flags"}, {sof, eol, eof}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    check_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, s0;
    tv[0] = '{1, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    tv[1] = '{1, 0, 1, 4, 0, 0, 1, 0, 1, 0};
    tv[2] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[3] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    tv[4] = '{1, 1, 1, 0, 1, 0, 0, 0, 1, 0};
    tv[5] = '{1, 0, 1, 4, 1, 0, 1, 1, 1, 0};
    tv[6] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    tv[7] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    tv[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tv[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1;
    // single frame, lanes and credits exercised cycle by cycle
    do_start();
    for (int r = 0; r < 10; r++) begin
      chk($sformatf("t2_valid[%0d]", r), out_valid, tv[r].v);
      if (tv[r].v) begin
        chk($sformatf("t2_x[%0d]", r), screen_x, lanes(tv[r].x));
        chk($sformatf("t2_y[%0d]", r), screen_y, 128'(32'(tv[r].y) << 21));
        chk($sformatf("t2_flags[%0d]", r), {sof, eol, eof}, {tv[r].sof, tv[r].eol, tv[r].eof});
      end
      chk($sformatf("t2_busy[%0d]", r), busy, tv[r].busy);
      chk($sformatf("t2_fc[%0d]", r), frame_cnt, 128'(tv[r].fc));
      cyc(tv[r].rdy, tv[r].ret);
    end
    // credit exhaustion with no returns, then a single return
    s0 = n_acc;
    do_start();
    repeat (6) cyc(1, 0);
    chk("t3_two_beats", n_acc - s0, 2);
    chk("t3_blocked", out_valid, 0);
    cyc(1, 1);
    repeat (5) cyc(1, 0);
    chk("t3_one_more", n_acc - s0, 3);
    chk("t3_blocked2", out_valid, 0);
    // reset mid-frame with credits in flight, then clean restart
    do_reset();
    echo = 1;
    do_start();
    chk("t6_first_sof", sof, 1);
    wait_idle(200);
    chk("t6_frames", frame_cnt, 1);
    // continuous scan under random backpressure, then stop
    continuous = 1;
    do_start();
    repeat (300) cyc(1'($urandom_range(0, 1)), 0);
    pulse_stop();
    wait_idle(200);
    chk("t4_scan_ended", run_model, 0);
    chk("t4_frames", frame_cnt, 128'(exp_frames));
    // stop during frame 2 of a continuous run
    do_reset();
    s0 = n_sof;
    do_start();
    k = 0;
    while (!(exp_frames == 1 && pix == 2) && k < 100) begin
      cyc(1, 0);
      k++;
    end
    chk("t5_reached_frame2", k < 100, 1);
    pulse_stop();
    wait_idle(200);
    chk("t5_frames", frame_cnt, 2);
    chk("t5_sof_count", n_sof - s0, 2);
    repeat (5) cyc(1, 0);
    chk("t5_stays_idle", {out_valid, busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
